// File: rtl/fft_sample_buffer.sv
// Sample/result buffer between a register bridge and a streaming FFT core.
// Samples are fed in bit-reversed order with zero padding; results are collected in arrival order.
module fft_sample_buffer #(
    parameter int LOG2_N       = 10,
    parameter int SAMPLE_WIDTH = 16,
    parameter int RESULT_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE,
    input  logic [11:0]             i_SAMPLE_INDEX,
    input  logic                    i_WRITE,
    input  logic                    i_READ,
    input  logic                    i_DATA_LOADED,
    output logic [RESULT_WIDTH-1:0] o_DATA_TO_BRIDGE,
    output logic                    o_CALC_END,
    output logic [11:0]             o_SAMPLES_NUMBER,
    output logic [SAMPLE_WIDTH-1:0] o_IN_DATA,
    output logic                    o_IN_VALID,
    output logic                    o_IN_LAST,
    input  logic                    i_IN_READY,
    input  logic [RESULT_WIDTH-1:0] i_OUT_DATA,
    input  logic                    i_OUT_VALID,
    input  logic                    i_OUT_LAST,
    output logic                    o_OUT_READY,
    output logic                    o_BUSY
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LOG2_N-1:0] f_q, f_d;
    logic [LOG2_N-1:0] c_q, c_d;
    logic [LOG2_N:0]   cnt_q, cnt_d;

    logic [SAMPLE_WIDTH-1:0] sample_ram [N];
    logic [RESULT_WIDTH-1:0] result_ram [N];

    logic              idx_ok;
    logic [LOG2_N-1:0] idx;
    logic [LOG2_N:0]   idx_plus1;
    logic [LOG2_N-1:0] feed_addr;
    logic              sample_we;
    logic              result_we;
    logic [12:0]       cnt_ext;

    function automatic logic [LOG2_N-1:0] bit_rev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = v[LOG2_N-1-i];
        end
        return r;
    endfunction

    assign idx_ok    = ({1'b0, i_SAMPLE_INDEX} < 13'(N));
    assign idx       = i_SAMPLE_INDEX[LOG2_N-1:0];
    assign idx_plus1 = {1'b0, idx} + (LOG2_N+1)'(1);
    assign feed_addr = bit_rev(f_q);

    // With LOG2_N=12 a full frame (4096) does not fit the 12-bit port; report 4095.
    assign cnt_ext          = 13'(cnt_q);
    assign o_SAMPLES_NUMBER = cnt_ext[12] ? 12'hFFF : cnt_ext[11:0];

    assign o_DATA_TO_BRIDGE = (i_READ && idx_ok) ? result_ram[idx] : '0;

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sample_we   = 1'b0;
        result_we   = 1'b0;
        o_IN_VALID  = 1'b0;
        o_IN_LAST   = 1'b0;
        o_IN_DATA   = '0;
        o_OUT_READY = 1'b0;
        o_CALC_END  = 1'b0;
        o_BUSY      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_WRITE && idx_ok) begin
                    sample_we = 1'b1;
                    if (idx_plus1 > cnt_q) cnt_d = idx_plus1;
                end
                if (i_DATA_LOADED) begin
                    state_d = S_FEED;
                    f_d     = '0;
                end
            end
            S_FEED: begin
                o_BUSY     = 1'b1;
                o_IN_VALID = 1'b1;
                // Addresses past the last written sample are zero-padded.
                o_IN_DATA  = ({1'b0, feed_addr} < cnt_q) ? sample_ram[feed_addr] : '0;
                o_IN_LAST  = (f_q == LAST_IDX);
                if (i_IN_READY) begin
                    f_d = f_q + 1'b1;
                    if (f_q == LAST_IDX) begin
                        state_d = S_COLLECT;
                        f_d     = '0;
                        c_d     = '0;
                    end
                end
            end
            S_COLLECT: begin
                o_BUSY      = 1'b1;
                o_OUT_READY = 1'b1;
                if (i_OUT_VALID) begin
                    result_we = 1'b1;
                    c_d       = c_q + 1'b1;
                    if (i_OUT_LAST || c_q == LAST_IDX) begin
                        state_d = S_DONE;
                        c_d     = '0;
                    end
                end
            end
            S_DONE: begin
                o_CALC_END = 1'b1;
                // A new bridge write starts the next frame; the count restarts from it.
                if (i_WRITE) begin
                    state_d   = S_IDLE;
                    sample_we = idx_ok;
                    cnt_d     = idx_ok ? idx_plus1 : '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (sample_we) sample_ram[idx] <= i_SAMPLE;
        if (result_we) result_ram[c_q] <= i_OUT_DATA;
    end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Directed bench for fft_sample_buffer at N=8: bit-reversed feed, zero padding,
// stalls, early/normal collect termination, async reset mid-frame.
module tb_fft_sample_buffer;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [15:0] i_SAMPLE;
    logic [11:0] i_SAMPLE_INDEX;
    logic        i_WRITE;
    logic        i_READ;
    logic        i_DATA_LOADED;
    logic [31:0] o_DATA_TO_BRIDGE;
    logic        o_CALC_END;
    logic [11:0] o_SAMPLES_NUMBER;
    logic [15:0] o_IN_DATA;
    logic        o_IN_VALID;
    logic        o_IN_LAST;
    logic        i_IN_READY;
    logic [31:0] i_OUT_DATA;
    logic        i_OUT_VALID;
    logic        i_OUT_LAST;
    logic        o_OUT_READY;
    logic        o_BUSY;

    int checks   = 0;
    int failures = 0;

    logic [15:0] seq_full [8];
    logic [15:0] seq_pad  [8];

    fft_sample_buffer #(.LOG2_N(3), .SAMPLE_WIDTH(16), .RESULT_WIDTH(32)) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_SAMPLE        (i_SAMPLE),
        .i_SAMPLE_INDEX  (i_SAMPLE_INDEX),
        .i_WRITE         (i_WRITE),
        .i_READ          (i_READ),
        .i_DATA_LOADED   (i_DATA_LOADED),
        .o_DATA_TO_BRIDGE(o_DATA_TO_BRIDGE),
        .o_CALC_END      (o_CALC_END),
        .o_SAMPLES_NUMBER(o_SAMPLES_NUMBER),
        .o_IN_DATA       (o_IN_DATA),
        .o_IN_VALID      (o_IN_VALID),
        .o_IN_LAST       (o_IN_LAST),
        .i_IN_READY      (i_IN_READY),
        .i_OUT_DATA      (i_OUT_DATA),
        .i_OUT_VALID     (i_OUT_VALID),
        .i_OUT_LAST      (i_OUT_LAST),
        .o_OUT_READY     (o_OUT_READY),
        .o_BUSY          (o_BUSY)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [15:0] val);
        i_WRITE        = 1'b1;
        i_SAMPLE_INDEX = 12'(idx);
        i_SAMPLE       = val;
        tick();
        i_WRITE = 1'b0;
    endtask

    initial begin
        seq_full = '{16'd1, 16'd5, 16'd3, 16'd7, 16'd2, 16'd6, 16'd4, 16'd8};
        seq_pad  = '{16'd1, 16'd5, 16'd3, 16'd0, 16'd2, 16'd0, 16'd4, 16'd0};

        i_rstn = 1'b0; i_SAMPLE = '0; i_SAMPLE_INDEX = '0; i_WRITE = 1'b0;
        i_READ = 1'b0; i_DATA_LOADED = 1'b0; i_IN_READY = 1'b0;
        i_OUT_DATA = '0; i_OUT_VALID = 1'b0; i_OUT_LAST = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(o_BUSY), 0);
        chk("rst_in_valid", 32'(o_IN_VALID), 0);
        chk("rst_samples", 32'(o_SAMPLES_NUMBER), 0);
        chk("rst_calc_end", 32'(o_CALC_END), 0);
        chk("rst_out_ready", 32'(o_OUT_READY), 0);
        i_rstn = 1'b1;
        tick();

        // Frame 1: full frame, last write coincides with the load pulse.
        for (int k = 0; k < 7; k++) wr(k, 16'(k + 1));
        chk("cnt_after7", 32'(o_SAMPLES_NUMBER), 7);
        i_WRITE = 1'b1; i_SAMPLE_INDEX = 12'd7; i_SAMPLE = 16'd8; i_DATA_LOADED = 1'b1;
        tick();
        i_WRITE = 1'b0; i_DATA_LOADED = 1'b0;
        chk("load_write_cnt", 32'(o_SAMPLES_NUMBER), 8);
        chk("feed_busy", 32'(o_BUSY), 1);
        chk("feed_valid", 32'(o_IN_VALID), 1);

        i_IN_READY = 1'b1; #1;
        chk("f1_data0", 32'(o_IN_DATA), 32'(seq_full[0]));
        chk("f1_last0", 32'(o_IN_LAST), 0);
        tick();
        i_IN_READY = 1'b0; #1;
        chk("stall_data_a", 32'(o_IN_DATA), 5);
        chk("stall_valid_a", 32'(o_IN_VALID), 1);
        tick();
        chk("stall_data_b", 32'(o_IN_DATA), 5);
        tick();
        chk("stall_data_c", 32'(o_IN_DATA), 5);
        i_IN_READY = 1'b1;
        for (int k = 1; k < 8; k++) begin
            #1;
            chk($sformatf("f1_data%0d", k), 32'(o_IN_DATA), 32'(seq_full[k]));
            chk($sformatf("f1_last%0d", k), 32'(o_IN_LAST), (k == 7) ? 1 : 0);
            tick();
        end
        i_IN_READY = 1'b0;
        chk("col_in_valid", 32'(o_IN_VALID), 0);
        chk("col_out_ready", 32'(o_OUT_READY), 1);
        chk("col_busy", 32'(o_BUSY), 1);
        chk("col_in_data", 32'(o_IN_DATA), 0);

        i_OUT_VALID = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_OUT_DATA = 32'h100 + 32'(k);
            i_OUT_LAST = (k == 7);
            tick();
        end
        i_OUT_VALID = 1'b0; i_OUT_LAST = 1'b0;
        chk("done_calc_end", 32'(o_CALC_END), 1);
        chk("done_busy", 32'(o_BUSY), 0);
        chk("done_out_ready", 32'(o_OUT_READY), 0);
        chk("done_cnt", 32'(o_SAMPLES_NUMBER), 8);
        i_READ = 1'b1; i_SAMPLE_INDEX = 12'd3; #1;
        chk("read_idx3", o_DATA_TO_BRIDGE, 32'h103);
        i_SAMPLE_INDEX = 12'd0; #1;
        chk("read_idx0", o_DATA_TO_BRIDGE, 32'h100);
        i_SAMPLE_INDEX = 12'd9; #1;
        chk("read_idx9", o_DATA_TO_BRIDGE, 0);
        i_READ = 1'b0; i_SAMPLE_INDEX = 12'd3; #1;
        chk("read_off", o_DATA_TO_BRIDGE, 0);
        i_DATA_LOADED = 1'b1;
        tick();
        i_DATA_LOADED = 1'b0;
        chk("done_load_ignored", 32'(o_BUSY), 0);
        chk("done_still", 32'(o_CALC_END), 1);

        // Frame 2: partial frame, zero padding, early i_OUT_LAST.
        wr(0, 16'd1);
        chk("restart_calc_end", 32'(o_CALC_END), 0);
        chk("restart_cnt", 32'(o_SAMPLES_NUMBER), 1);
        for (int k = 1; k < 5; k++) wr(k, 16'(k + 1));
        wr(9, 16'hBEEF);
        chk("cnt5", 32'(o_SAMPLES_NUMBER), 5);
        i_DATA_LOADED = 1'b1;
        tick();
        i_DATA_LOADED = 1'b0;
        i_IN_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_WRITE = (k == 0); i_SAMPLE_INDEX = 12'd6; i_SAMPLE = 16'h77;
            #1;
            chk($sformatf("f2_data%0d", k), 32'(o_IN_DATA), 32'(seq_pad[k]));
            tick();
            i_WRITE = 1'b0;
            if (k == 0) chk("feed_write_ignored", 32'(o_SAMPLES_NUMBER), 5);
        end
        i_IN_READY = 1'b0;
        i_OUT_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_OUT_DATA = 32'h200 + 32'(k);
            i_OUT_LAST = (k == 2);
            tick();
        end
        i_OUT_VALID = 1'b0; i_OUT_LAST = 1'b0;
        chk("early_done", 32'(o_CALC_END), 1);
        i_READ = 1'b1; i_SAMPLE_INDEX = 12'd2; #1;
        chk("read_new2", o_DATA_TO_BRIDGE, 32'h202);
        i_SAMPLE_INDEX = 12'd3; #1;
        chk("read_old3", o_DATA_TO_BRIDGE, 32'h103);
        i_READ = 1'b0;

        // Frame 3: reset asserted at f=4, then a clean frame.
        for (int k = 0; k < 8; k++) wr(k, 16'h10 + 16'(k));
        i_DATA_LOADED = 1'b1;
        tick();
        i_DATA_LOADED = 1'b0;
        i_IN_READY = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("f4_data", 32'(o_IN_DATA), 32'h11);
        #2;
        i_rstn = 1'b0; #1;
        chk("arst_valid", 32'(o_IN_VALID), 0);
        chk("arst_cnt", 32'(o_SAMPLES_NUMBER), 0);
        chk("arst_busy", 32'(o_BUSY), 0);
        tick();
        i_rstn = 1'b1;
        i_IN_READY = 1'b0;
        tick();
        chk("post_rst_idle", 32'(o_IN_VALID), 0);
        for (int k = 0; k < 8; k++) wr(k, 16'h20 + 16'(k));
        i_DATA_LOADED = 1'b1;
        tick();
        i_DATA_LOADED = 1'b0;
        i_IN_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("f3_data%0d", k), 32'(o_IN_DATA), 32'h20 + 32'(seq_full[k]) - 1);
            chk($sformatf("f3_last%0d", k), 32'(o_IN_LAST), (k == 7) ? 1 : 0);
            tick();
        end
        i_IN_READY = 1'b0;
        chk("f3_collect", 32'(o_OUT_READY), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
